clk_switch_sequencer: RTL and testbench

- Sequences glitch-free switching of the target-core clock source (PLL vs. TIO clock input) through the BUFGCTRL select pins and the clock wizard enable.
- Holds the Cortex-M3 subsystem in reset across every switch.
- Runs on an always-present control clock, independent of the muxed clock.
- Sits at top level between the select DIP/pin, the BUFGCTRL S0/S1 inputs, and the core reset input.

---
 rtl/clk_switch_sequencer.sv | 156 +++++++++++++++
 tb/tb_clk_switch_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_switch_sequencer.sv
// Glitch-free PLL/TIO clock-source switch sequencer for the target core.
// Holds the M3 in reset, parks BUFGCTRL with no source selected, reselects, waits for lock.
module clk_switch_sequencer #(
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int RST_PRE_CYCLES  = 16,
  parameter int GAP_CYCLES      = 8,
  parameter int LOCK_TIMEOUT    = 65535,
  parameter int RST_POST_CYCLES = 64,
  parameter int CNT_W           = 17
) (
  input  logic ctrl_clock,
  input  logic reset,
  input  logic sel_req,
  input  logic wiz_enable_req,
  input  logic wiz_locked,
  input  logic trig_in,
  output logic bufg_s0,
  output logic bufg_s1,
  output logic clk_wiz_enable,
  output logic core_reset_n,
  output logic cur_sel,
  output logic busy,
  output logic lock_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_GAP  = 3'd2;
  localparam logic [2:0] ST_LOCK = 3'd3;
  localparam logic [2:0] ST_POST = 3'd4;

  // A zero delay still occupies its state for one cycle.
  localparam int DB_N   = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
  localparam int PRE_N  = (RST_PRE_CYCLES  < 1) ? 1 : RST_PRE_CYCLES;
  localparam int GAP_N  = (GAP_CYCLES      < 1) ? 1 : GAP_CYCLES;
  localparam int LOCK_N = (LOCK_TIMEOUT    < 1) ? 1 : LOCK_TIMEOUT;
  localparam int POST_N = (RST_POST_CYCLES < 1) ? 1 : RST_POST_CYCLES;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_N - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_N - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_N - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_N - 1);
  localparam logic [CNT_W-1:0] POST_LAST = CNT_W'(POST_N - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  // Bit order: {trig, locked, enable, sel}
  logic [3:0] raw, sync_q1, sync_q2;
  logic       s_sel, s_en, s_lock, s_trig;

  assign raw    = {trig_in, wiz_locked, wiz_enable_req, sel_req};
  assign s_sel  = sync_q2[0];
  assign s_en   = sync_q2[1];
  assign s_lock = sync_q2[2];
  assign s_trig = sync_q2[3];

  always_ff @(posedge ctrl_clock or negedge reset) begin
    if (!reset) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw;
      sync_q2 <= sync_q1;
    end
  end

  logic             sel_db;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge ctrl_clock or negedge reset) begin
    if (!reset) begin
      sel_db <= 1'b0;
      db_cnt <= '0;
    end else if (s_sel != sel_db) begin
      if (db_cnt == DB_LAST) begin
        sel_db <= s_sel;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + ONE;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             target;

  always_ff @(posedge ctrl_clock or negedge reset) begin
    if (!reset) begin
      state          <= ST_PRE;
      cnt            <= '0;
      target         <= 1'b0;
      bufg_s0        <= 1'b0;
      bufg_s1        <= 1'b0;
      clk_wiz_enable <= 1'b0;
      core_reset_n   <= 1'b0;
      cur_sel        <= 1'b0;
      busy           <= 1'b1;
      lock_err       <= 1'b0;
    end else begin
      cnt <= cnt + ONE;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // A pending request waits out any capture in progress.
          if (sel_db != cur_sel && !s_trig) begin
            target       <= sel_db;
            state        <= ST_PRE;
            core_reset_n <= 1'b0;
            busy         <= 1'b1;
          end
        end
        ST_PRE: if (cnt == PRE_LAST) begin
          cnt     <= '0;
          state   <= ST_GAP;
          bufg_s0 <= 1'b0;
          bufg_s1 <= 1'b0;
        end
        ST_GAP: if (cnt == GAP_LAST) begin
          cnt            <= '0;
          state          <= ST_LOCK;
          bufg_s0        <= ~target;
          bufg_s1        <= target;
          cur_sel        <= target;
          clk_wiz_enable <= s_en;
        end
        ST_LOCK: begin
          if (!clk_wiz_enable || s_lock) begin
            cnt   <= '0;
            state <= ST_POST;
          end else if (cnt == LOCK_LAST) begin
            cnt      <= '0;
            state    <= ST_POST;
            lock_err <= 1'b1;
          end
        end
        ST_POST: if (cnt == POST_LAST) begin
          cnt          <= '0;
          state        <= ST_IDLE;
          core_reset_n <= 1'b1;
          busy         <= 1'b0;
        end
        default: begin
          cnt          <= '0;
          state        <= ST_PRE;
          bufg_s0      <= 1'b0;
          bufg_s1      <= 1'b0;
          core_reset_n <= 1'b0;
          busy         <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_switch_sequencer.sv
// Bench for clk_switch_sequencer: a sequence-timeline model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_clk_switch_sequencer;

  localparam int DEB  = 20;
  localparam int PRE  = 16;
  localparam int GAP  = 8;
  localparam int LT   = 200;
  localparam int POST = 64;

  logic ctrl_clock;
  logic reset;
  logic sel_req, wiz_enable_req, wiz_locked, trig_in;
  logic bufg_s0, bufg_s1, clk_wiz_enable, core_reset_n, cur_sel, busy, lock_err;

  int n_cmp = 0;
  int n_err = 0;
  int n_print = 0;

  clk_switch_sequencer #(
    .DEBOUNCE_CYCLES(DEB), .RST_PRE_CYCLES(PRE), .GAP_CYCLES(GAP),
    .LOCK_TIMEOUT(LT), .RST_POST_CYCLES(POST), .CNT_W(17)
  ) dut (
    .ctrl_clock(ctrl_clock), .reset(reset),
    .sel_req(sel_req), .wiz_enable_req(wiz_enable_req),
    .wiz_locked(wiz_locked), .trig_in(trig_in),
    .bufg_s0(bufg_s0), .bufg_s1(bufg_s1), .clk_wiz_enable(clk_wiz_enable),
    .core_reset_n(core_reset_n), .cur_sel(cur_sel), .busy(busy), .lock_err(lock_err)
  );

  initial begin
    ctrl_clock = 1'b0;
    forever #5 ctrl_clock = ~ctrl_clock;
  end

  // Model: a switch is a timeline of positions; phase boundaries are PRE, PRE+GAP,
  // end of lock wait (found at run time) and POST cycles after that.
  logic [3:0] mq1, mq2;
  logic m_busy, m_tgt, m_cur, m_en, m_err, m_rstn, m_s0, m_s1, m_db;
  int   m_pos, m_post_at, m_run;

  task automatic model_reset();
    mq1 = '0; mq2 = '0;
    m_busy = 1'b1; m_pos = 0; m_post_at = -1; m_tgt = 1'b0;
    m_cur = 1'b0; m_en = 1'b0; m_err = 1'b0; m_rstn = 1'b0;
    m_s0 = 1'b0; m_s1 = 1'b0; m_db = 1'b0; m_run = 0;
  endtask

  task automatic model_step();
    logic [3:0] sy;
    int nxt;
    sy  = mq2;
    mq2 = mq1;
    mq1 = {trig_in, wiz_locked, wiz_enable_req, sel_req};
    if (!m_busy) begin
      if (m_db != m_cur && !sy[3]) begin
        m_busy = 1'b1; m_pos = 0; m_post_at = -1; m_tgt = m_db; m_rstn = 1'b0;
      end
    end else begin
      nxt = m_pos + 1;
      if (m_pos == PRE - 1) begin m_s0 = 1'b0; m_s1 = 1'b0; end
      if (m_pos == PRE + GAP - 1) begin
        m_s0 = ~m_tgt; m_s1 = m_tgt; m_cur = m_tgt; m_en = sy[1];
      end
      if (m_pos >= PRE + GAP && m_post_at < 0) begin
        if (!m_en || sy[2]) m_post_at = nxt;
        else if (m_pos - (PRE + GAP) == LT - 1) begin m_err = 1'b1; m_post_at = nxt; end
      end
      if (m_post_at >= 0 && nxt == m_post_at + POST) begin m_busy = 1'b0; m_rstn = 1'b1; end
      m_pos = nxt;
    end
    if (sy[0] != m_db) begin
      m_run++;
      if (m_run == DEB) begin m_db = sy[0]; m_run = 0; end
    end else m_run = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge ctrl_clock or negedge reset);
      if (!reset) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model
  initial begin
    logic [6:0] act, exp_v;
    forever begin
      @(negedge ctrl_clock);
      act   = {bufg_s0, bufg_s1, clk_wiz_enable, core_reset_n, cur_sel, busy, lock_err};
      exp_v = {m_s0, m_s1, m_en, m_rstn, m_cur, m_busy, m_err};
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        if (n_print < 20) begin
          n_print++;
          $display("FAIL model_cycle t=%0t: got s0,s1,en,rstn,cur,busy,err=%b want %b", $time, act, exp_v);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %b want %b", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge ctrl_clock);
  endtask

  function automatic logic [6:0] outs();
    return {bufg_s0, bufg_s1, clk_wiz_enable, core_reset_n, cur_sel, busy, lock_err};
  endfunction

  initial begin
    reset = 1'b0; sel_req = 1'b0; wiz_enable_req = 1'b1; wiz_locked = 1'b0; trig_in = 1'b0;
    step(3);
    chk("reset_values", outs(), 7'b0000010);

    // Power-up sequence to PLL
    reset = 1'b1;
    step(23);
    chk("pwrup_gap_sel", {5'b0, bufg_s0, bufg_s1}, 7'b0000000);
    chk("pwrup_busy", {6'b0, busy}, 7'd1);
    step(1);
    chk("pwrup_s0_on", {5'b0, bufg_s0, clk_wiz_enable}, 7'b0000011);
    step(76);
    wiz_locked = 1'b1;
    step(66);
    chk("pwrup_rstn_held", {6'b0, core_reset_n}, 7'd0);
    step(1);
    chk("pwrup_release", {5'b0, core_reset_n, busy}, 7'b0000010);

    // PLL -> TIO
    sel_req = 1'b1;
    step(DEB + 2);
    chk("sw1_quiet", {5'b0, core_reset_n, busy}, 7'b0000010);
    step(1);
    chk("sw1_rst_fall", {5'b0, core_reset_n, busy}, 7'b0000001);
    step(15);
    chk("sw1_s0_still", {5'b0, bufg_s0, bufg_s1}, 7'b0000010);
    step(1);
    chk("sw1_gap_start", {5'b0, bufg_s0, bufg_s1}, 7'b0000000);
    step(7);
    chk("sw1_gap_end", {5'b0, bufg_s0, bufg_s1}, 7'b0000000);
    step(1);
    chk("sw1_tio_sel", {4'b0, bufg_s0, bufg_s1, cur_sel}, 7'b0000011);
    step(64);
    chk("sw1_post_held", {6'b0, core_reset_n}, 7'd0);
    step(1);
    chk("sw1_release", {5'b0, core_reset_n, busy}, 7'b0000010);

    // Glitch shorter than the debounce window
    sel_req = 1'b0;
    step(DEB - 5);
    sel_req = 1'b1;
    step(40);
    chk("glitch_ignored", {3'b0, bufg_s0, bufg_s1, cur_sel, busy}, 7'b0000110);

    // Capture deferral
    trig_in = 1'b1;
    sel_req = 1'b0;
    step(DEB + 10);
    chk("capture_hold", {4'b0, core_reset_n, cur_sel, busy}, 7'b0000110);
    trig_in = 1'b0;
    step(2);
    chk("capture_wait", {5'b0, core_reset_n, busy}, 7'b0000010);
    step(1);
    chk("capture_start", {5'b0, core_reset_n, busy}, 7'b0000001);
    step(100);
    chk("capture_done", {4'b0, bufg_s0, cur_sel, busy}, 7'b0000100);

    // Lock timeout
    wiz_locked = 1'b0;
    sel_req = 1'b1;
    step(DEB + 3);
    chk("to_pre", {6'b0, busy}, 7'd1);
    step(PRE + GAP);
    chk("to_lock_entry", {4'b0, bufg_s1, clk_wiz_enable, lock_err}, 7'b0000110);
    step(LT - 1);
    chk("to_not_yet", {5'b0, core_reset_n, lock_err}, 7'b0000000);
    step(1);
    chk("to_err_set", {5'b0, core_reset_n, lock_err}, 7'b0000001);
    step(POST - 1);
    chk("to_post_held", {6'b0, core_reset_n}, 7'd0);
    step(1);
    chk("to_release", {4'b0, core_reset_n, busy, lock_err}, 7'b0000101);
    wiz_locked = 1'b1;
    sel_req = 1'b0;
    step(150);
    chk("err_sticky", {4'b0, cur_sel, busy, lock_err}, 7'b0000001);

    // Async reset while in GAP
    sel_req = 1'b1;
    step(DEB + 3);
    step(PRE + 3);
    chk("gap_state", {4'b0, bufg_s0, bufg_s1, busy}, 7'b0000001);
    #2 reset = 1'b0;
    #1 chk("async_reset_vals", outs(), 7'b0000010);
    @(negedge ctrl_clock);
    step(2);
    reset = 1'b1;
    step(24);
    chk("restart_pll", {4'b0, bufg_s0, bufg_s1, cur_sel}, 7'b0000100);
    step(64);
    chk("restart_post", {6'b0, core_reset_n}, 7'd0);
    step(1);
    chk("reentry_pulse_hi", {5'b0, core_reset_n, busy}, 7'b0000010);
    step(1);
    chk("reentry_restart", {5'b0, core_reset_n, busy}, 7'b0000001);
    step(100);
    chk("restart_tio", {4'b0, bufg_s1, cur_sel, busy}, 7'b0000110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
